// File: rtl/sha512_msg_ctrl_pkg.sv
// Shared SHA-512 types, FIPS 180-4 initial hash and the sigma helpers used by the chunk core.
package sha512_pkg;

    typedef logic [0:7][63:0] sha512_hash_t;
    typedef logic [1023:0]    sha512_chunk_t;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, UPDATE, OUT} msg_state_t;

    localparam sha512_hash_t SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

endpackage

// File: rtl/sha512_msg_ctrl_if.sv
// Chunk input stream and digest output stream of the SHA-512 message sequencer.
interface sha512_msg_ctrl_if;
    import sha512_pkg::*;

    logic          chunk_valid;
    logic          chunk_ready;
    sha512_chunk_t chunk_data;
    logic          chunk_first;
    logic          chunk_last;
    logic          dig_valid;
    logic          dig_ready;
    sha512_hash_t  dig_data;

    modport master (
        output chunk_valid, chunk_data, chunk_first, chunk_last, dig_ready,
        input  chunk_ready, dig_valid, dig_data
    );

    modport slave (
        input  chunk_valid, chunk_data, chunk_first, chunk_last, dig_ready,
        output chunk_ready, dig_valid, dig_data
    );

endinterface

// File: rtl/sha512_msg_ctrl_chunk.sv
// Single-chunk SHA-512 compression: birth, init, 80 rounds, then done (level) with oH = iH + vars.
module sha512_chunk
    import sha512_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  sha512_chunk_t chunk,
    input  sha512_hash_t  iH,
    output logic          done,
    output sha512_hash_t  oH
);

    localparam logic [0:79][63:0] K = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // step 0 = birth, 1 = init, 2..81 = rounds 0..79, 82 = finished
    logic [6:0]        step;
    logic [6:0]        round;
    sha512_hash_t      v;
    logic [0:15][63:0] w;
    logic [0:15][63:0] chunk_words;
    logic [63:0]       k_t;
    logic [63:0]       t1;
    logic [63:0]       t2;
    logic [63:0]       w_new;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_words
            assign chunk_words[gi] = chunk[1023-64*gi -: 64];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_out
            assign oH[gi] = iH[gi] + v[gi];
        end
    endgenerate

    assign round = step - 7'd2;
    assign k_t   = K[round];

    always_comb begin
        t1    = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_t + w[0];
        t2    = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= 7'd0;
            done <= 1'b0;
            v    <= '0;
            w    <= '0;
        end else if (step == 7'd0) begin
            step <= 7'd1;
        end else if (step == 7'd1) begin
            v    <= iH;
            w    <= chunk_words;
            step <= 7'd2;
        end else if (step <= 7'd81) begin
            v    <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
            w    <= {w[1:15], w_new};
            step <= step + 7'd1;
            if (step == 7'd81) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha512_msg_ctrl.sv
// SHA-512 message sequencer: registers chunk and running hash, restarts the core per chunk,
// chains its output hash and presents the final digest.
module sha512_msg_ctrl
    import sha512_pkg::*;
#(
    parameter sha512_hash_t IV       = SHA512_IV,
    parameter int           WDOG_MAX = 96
) (
    input  logic                clk,
    input  logic                reset,
    sha512_msg_ctrl_if.slave    bus,
    input  logic                abort,
    output logic                err,
    output logic                core_reset,
    output sha512_chunk_t       core_chunk,
    output sha512_hash_t        core_iH,
    output logic                core_done,
    output sha512_hash_t        core_oH
);

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    msg_state_t        state;
    sha512_hash_t      hash;
    logic              last_q;
    logic              in_msg;
    logic              dig_valid;
    logic [WDOG_W-1:0] wdog;
    logic              handshake;

    assign bus.chunk_ready = (state == IDLE) && !abort;
    assign handshake       = bus.chunk_valid && bus.chunk_ready;
    assign bus.dig_valid   = dig_valid;
    assign bus.dig_data    = hash;

    sha512_chunk u_core (
        .clk   (clk),
        .rst_n (core_reset),
        .chunk (core_chunk),
        .iH    (core_iH),
        .done  (core_done),
        .oH    (core_oH)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            core_reset <= 1'b0;
            hash       <= IV;
            dig_valid  <= 1'b0;
            err        <= 1'b0;
            wdog       <= '0;
            in_msg     <= 1'b0;
            last_q     <= 1'b0;
            core_chunk <= '0;
            core_iH    <= IV;
        end else if (abort) begin
            state      <= IDLE;
            core_reset <= 1'b0;
            dig_valid  <= 1'b0;
            in_msg     <= 1'b0;
            hash       <= IV;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        // a chunk arriving outside a message always starts a fresh one
                        core_chunk <= bus.chunk_data;
                        core_iH    <= (bus.chunk_first || !in_msg) ? IV : hash;
                        last_q     <= bus.chunk_last;
                        if (bus.chunk_first) begin
                            err <= 1'b0;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    core_reset <= 1'b1;
                    wdog       <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    wdog <= wdog + WDOG_W'(1);
                    if (core_done) begin
                        hash       <= core_oH;
                        core_reset <= 1'b0;
                        state      <= UPDATE;
                    end else if (wdog == WDOG_W'(WDOG_MAX - 1)) begin
                        err        <= 1'b1;
                        in_msg     <= 1'b0;
                        hash       <= IV;
                        core_reset <= 1'b0;
                        state      <= IDLE;
                    end
                end
                UPDATE: begin
                    if (last_q) begin
                        dig_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        in_msg <= 1'b1;
                        state  <= IDLE;
                    end
                end
                OUT: begin
                    if (bus.dig_ready) begin
                        dig_valid <= 1'b0;
                        in_msg    <= 1'b0;
                        hash      <= IV;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_msg_ctrl.sv
// Directed bench for sha512_msg_ctrl using FIPS 180-4 SHA-512 example messages.
module tb_sha512_msg_ctrl;
    import sha512_pkg::*;

    localparam logic [511:0] IV_EXP = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] ABC_DIG = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] TWO_DIG = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
    localparam logic [895:0] MSG2 = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
    localparam sha512_chunk_t ABC_BLK = {24'h616263, 8'h80, 864'h0, 128'h18};
    localparam sha512_chunk_t BLK1    = {MSG2, 8'h80, 120'h0};
    localparam sha512_chunk_t BLK2    = {896'h0, 128'd896};

    logic          clk = 1'b0;
    logic          reset;
    logic          abort;
    logic          err;
    logic          core_reset;
    sha512_chunk_t core_chunk;
    sha512_hash_t  core_iH;
    logic          core_done;
    sha512_hash_t  core_oH;

    int vectors     = 0;
    int miscompares = 0;

    sha512_msg_ctrl_if bus ();

    sha512_msg_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .abort      (abort),
        .err        (err),
        .core_reset (core_reset),
        .core_chunk (core_chunk),
        .core_iH    (core_iH),
        .core_done  (core_done),
        .core_oH    (core_oH)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Presents a chunk from a negedge; returns at the negedge just after the accepting edge.
    task automatic offer(input sha512_chunk_t d, input logic f, input logic l, output bit acc);
        bus.chunk_data  = d;
        bus.chunk_first = f;
        bus.chunk_last  = l;
        bus.chunk_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            #1;
            if (bus.chunk_ready === 1'b1) acc = 1'b1;
            @(negedge clk);
        end
        bus.chunk_valid = 1'b0;
        $display("chunk offered first=%b last=%b accepted=%b", f, l, acc);
    endtask

    task automatic wait_dig(output int cyc);
        cyc = 0;
        while (bus.dig_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        $display("digest after %0d clocks: %h (core_oH[0]=%h)", cyc, bus.dig_data, core_oH[0]);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.chunk_ready !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume;
        bus.dig_ready = 1'b1;
        @(negedge clk);
        bus.dig_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.chunk_ready !== 1'b1) begin miscompares++; $display("FAIL reset_chunk_ready: got %b want 1", bus.chunk_ready); end
        vectors++; if (bus.dig_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dig_valid: got %b want 0", bus.dig_valid); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (core_reset !== 1'b0) begin miscompares++; $display("FAIL reset_core_reset: got %b want 0", core_reset); end
        vectors++; if (bus.dig_data !== IV_EXP) begin miscompares++; $display("FAIL reset_dig_data: got %h want %h", bus.dig_data, IV_EXP); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc;
        bit acc;
        int cyc;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL abc_accept: got %b want 1", acc); end
        vectors++; if (core_chunk !== ABC_BLK) begin miscompares++; $display("FAIL abc_core_chunk: got %h want %h", core_chunk, ABC_BLK); end
        vectors++; if (core_iH !== IV_EXP) begin miscompares++; $display("FAIL abc_core_iH: got %h want %h", core_iH, IV_EXP); end
        vectors++; if (core_reset !== 1'b0 || bus.chunk_ready !== 1'b0) begin miscompares++; $display("FAIL abc_load_state: core_reset=%b chunk_ready=%b want 0 0", core_reset, bus.chunk_ready); end
        @(negedge clk);
        vectors++; if (core_reset !== 1'b1) begin miscompares++; $display("FAIL abc_core_reset_run: got %b want 1", core_reset); end
        wait_dig(cyc);
        vectors++; if (cyc != 84) begin miscompares++; $display("FAIL abc_latency: got %0d want 85", cyc + 1); end
        vectors++; if (bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest: got %h want %h", bus.dig_data, ABC_DIG); end
        consume();
        vectors++; if (bus.dig_valid !== 1'b0 || bus.chunk_ready !== 1'b1) begin miscompares++; $display("FAIL abc_after_consume: dig_valid=%b chunk_ready=%b want 0 1", bus.dig_valid, bus.chunk_ready); end
    endtask

    task automatic test_two_chunk;
        bit acc;
        int cyc;
        offer(BLK1, 1'b1, 1'b0, acc);
        vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL two_accept1: got %b want 1", acc); end
        wait_ready(cyc);
        vectors++; if (cyc != 85) begin miscompares++; $display("FAIL two_ready_gap: got %0d want 85", cyc); end
        vectors++; if (bus.dig_valid !== 1'b0) begin miscompares++; $display("FAIL two_no_mid_digest: got %b want 0", bus.dig_valid); end
        offer(BLK2, 1'b0, 1'b1, acc);
        vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL two_accept2: got %b want 1", acc); end
        wait_dig(cyc);
        vectors++; if (cyc != 85) begin miscompares++; $display("FAIL two_latency: got %0d want 85", cyc); end
        vectors++; if (bus.dig_data !== TWO_DIG) begin miscompares++; $display("FAIL two_digest: got %h want %h", bus.dig_data, TWO_DIG); end
        consume();
    endtask

    task automatic test_hold;
        bit acc;
        bit bad;
        int cyc;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        wait_dig(cyc);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dig_data !== ABC_DIG || bus.dig_valid !== 1'b1 || bus.chunk_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL hold_stable: dig_data=%h dig_valid=%b want %h 1", bus.dig_data, bus.dig_valid, ABC_DIG); end
        vectors++; if (bus.chunk_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready_low: got %b want 0", bus.chunk_ready); end
        consume();
        vectors++; if (bus.chunk_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready_after: got %b want 1", bus.chunk_ready); end
        vectors++; if (bus.dig_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid_after: got %b want 0", bus.dig_valid); end
    endtask

    task automatic test_abort;
        bit acc;
        bit bad;
        int cyc;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        repeat (39) @(negedge clk);
        abort = 1'b1;
        bus.chunk_data  = BLK1;
        bus.chunk_first = 1'b1;
        bus.chunk_valid = 1'b1;
        #1;
        vectors++; if (bus.chunk_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready_low: got %b want 0", bus.chunk_ready); end
        @(negedge clk);
        abort = 1'b0;
        bus.chunk_valid = 1'b0;
        #1;
        vectors++; if (core_reset !== 1'b0) begin miscompares++; $display("FAIL abort_core_reset: got %b want 0", core_reset); end
        vectors++; if (bus.chunk_ready !== 1'b1) begin miscompares++; $display("FAIL abort_idle: chunk_ready got %b want 1", bus.chunk_ready); end
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.dig_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL abort_no_digest: dig_valid seen high, want 0"); end
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        wait_dig(cyc);
        vectors++; if (cyc != 85 || bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL abort_recover: latency %0d digest %h want 85 %h", cyc, bus.dig_data, ABC_DIG); end
        consume();
    endtask

    task automatic test_first_restart;
        bit acc;
        int cyc;
        offer(BLK1, 1'b1, 1'b0, acc);
        wait_ready(cyc);
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        vectors++; if (core_iH !== IV_EXP) begin miscompares++; $display("FAIL restart_iH: got %h want %h", core_iH, IV_EXP); end
        wait_dig(cyc);
        vectors++; if (bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL restart_digest: got %h want %h", bus.dig_data, ABC_DIG); end
        consume();
        offer(ABC_BLK, 1'b0, 1'b1, acc);
        wait_dig(cyc);
        vectors++; if (bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL nofirst_digest: got %h want %h", bus.dig_data, ABC_DIG); end
        consume();
    endtask

    task automatic test_watchdog;
        bit acc;
        int cyc;
        force dut.core_done = 1'b0;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        repeat (96) @(negedge clk);
        vectors++; if (err !== 1'b0 || bus.chunk_ready !== 1'b0) begin miscompares++; $display("FAIL wdog_early: err=%b chunk_ready=%b want 0 0", err, bus.chunk_ready); end
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wdog_err: got %b want 1", err); end
        vectors++; if (bus.chunk_ready !== 1'b1 || core_reset !== 1'b0 || bus.dig_valid !== 1'b0) begin miscompares++; $display("FAIL wdog_idle: chunk_ready=%b core_reset=%b dig_valid=%b want 1 0 0", bus.chunk_ready, core_reset, bus.dig_valid); end
        release dut.core_done;
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wdog_sticky: got %b want 1", err); end
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wdog_clear: got %b want 0", err); end
        wait_dig(cyc);
        vectors++; if (cyc != 85 || bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL wdog_recover: latency %0d digest %h want 85 %h", cyc, bus.dig_data, ABC_DIG); end
        consume();
    endtask

    task automatic test_async_reset;
        bit acc;
        int cyc;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        repeat (30) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++; if (core_reset !== 1'b0) begin miscompares++; $display("FAIL arst_run_core_reset: got %b want 0", core_reset); end
        vectors++; if (bus.chunk_ready !== 1'b1 || bus.dig_valid !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL arst_run_outputs: ready=%b valid=%b err=%b want 1 0 0", bus.chunk_ready, bus.dig_valid, err); end
        @(negedge clk);
        reset = 1'b1;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        wait_dig(cyc);
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus.dig_valid !== 1'b0 || bus.dig_data !== IV_EXP) begin miscompares++; $display("FAIL arst_out: dig_valid=%b dig_data=%h want 0 %h", bus.dig_valid, bus.dig_data, IV_EXP); end
        @(negedge clk);
        reset = 1'b1;
        offer(ABC_BLK, 1'b1, 1'b1, acc);
        wait_dig(cyc);
        vectors++; if (cyc != 85 || bus.dig_data !== ABC_DIG) begin miscompares++; $display("FAIL arst_recover: latency %0d digest %h want 85 %h", cyc, bus.dig_data, ABC_DIG); end
        consume();
    endtask

    initial begin
        reset           = 1'b0;
        abort           = 1'b0;
        bus.chunk_valid = 1'b0;
        bus.chunk_data  = '0;
        bus.chunk_first = 1'b0;
        bus.chunk_last  = 1'b0;
        bus.dig_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_two_chunk();
        test_hold();
        test_abort();
        test_first_restart();
        test_watchdog();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
